// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and state encoding for the mux8 round-robin arbiter.
package mux8_rr_arbiter_pkg;

    localparam int N_REQ        = 8;
    localparam int SEL_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin pick: rotate by ptr, find first set bit, un-rotate.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[3'(i) + ptr];
        end
        // Scan from the top so the lowest set bit wins.
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        any    = |req;
        idx    = off + ptr;
        onehot = 8'd1 << idx;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner FSM driving the select lines of a shared 8:1 mux.
// Optional hold timeout enabled by defining MUX8_ARB_HOLD_TIMEOUT_EN.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             busy,
    output logic             preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux8_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
`endif

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        preempt_d   = 1'b0;
`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
        hold_d      = hold_q;
`endif
        case (state_q)
            // GAP is the single dead cycle; arbitrating here too keeps a
            // handoff to exactly one zero-grant cycle.
            IDLE, GAP: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    gnt_d       = pick_onehot;
                    sel_d       = pick_idx;
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    ptr_d       = pick_idx + 3'd1;
`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
                    hold_d      = '0;
`endif
                end else begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                end
`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
                else if (hold_q == HOLD_LAST && |(req & ~gnt_q)) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    sel_valid_d = 1'b0;
                    preempt_d   = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            preempt_q   <= 1'b0;
`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            preempt_q   <= preempt_d;
`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
    assign preempt   = preempt_q;
`else
    assign preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter (MAX_HOLD overridden to 4).
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       preempt;

    int n_tests = 0;
    int n_fail  = 0;

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = 8'hFF;
        rst_n = 1'b0;
        repeat (2) step();
        n_tests++;
        if ({gnt, sel, sel_valid, busy, preempt} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%h sel=%0d v=%b busy=%b pre=%b, want all 0",
                     gnt, sel, sel_valid, busy, preempt);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (gnt !== 8'h01 || sel !== 3'd0 || sel_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: got gnt=%h sel=%0d v=%b busy=%b, want 01/0/1/1",
                     gnt, sel, sel_valid, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h20;
        step();
        n_tests++;
        if (gnt !== 8'h20 || sel !== 3'd5 || sel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%h sel=%0d v=%b, want 20/5/1", gnt, sel, sel_valid);
        end
        req = 8'h00;
        step();
        n_tests++;
        if (gnt !== 8'h00 || sel !== 3'd5 || sel_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_gap: got gnt=%h sel=%0d v=%b busy=%b, want 00/5/0/1",
                     gnt, sel, sel_valid, busy);
        end
        step();
        n_tests++;
        if (gnt !== 8'h00 || sel !== 3'd5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got gnt=%h sel=%0d busy=%b, want 00/5/0", gnt, sel, busy);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_g = 8'd1 << (i % 8);
            step();
            n_tests++;
            if (gnt !== exp_g || sel !== 3'(i % 8) || sel_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation_grant[%0d]: got gnt=%h sel=%0d v=%b, want %h/%0d/1",
                         i, gnt, sel, sel_valid, exp_g, i % 8);
            end
            req = 8'hFF & ~exp_g;
            step();
            n_tests++;
            if (gnt !== 8'h00 || sel_valid !== 1'b0 || sel !== 3'(i % 8)) begin
                n_fail++;
                $display("FAIL rotation_gap[%0d]: got gnt=%h v=%b sel=%0d, want 00/0/%0d",
                         i, gnt, sel_valid, sel, i % 8);
            end
            req = 8'hFF;
        end
    endtask

    task automatic test_ptr_advance();
        do_reset();
        req = 8'h10;
        step();
        req = 8'h00;
        step();
        req = 8'hFF;
        step();
        n_tests++;
        if (gnt !== 8'h20 || sel !== 3'd5) begin
            n_fail++;
            $display("FAIL ptr_after_winner: got gnt=%h sel=%0d, want 20/5", gnt, sel);
        end
    endtask

    task automatic test_ignore_others();
        do_reset();
        req = 8'h04;
        step();
        req = 8'h84;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (gnt !== 8'h04 || sel !== 3'd2) begin
                n_fail++;
                $display("FAIL ignore_hold[%0d]: got gnt=%h sel=%0d, want 04/2", i, gnt, sel);
            end
        end
        req = 8'h80;
        step();
        n_tests++;
        if (gnt !== 8'h00 || sel !== 3'd2) begin
            n_fail++;
            $display("FAIL ignore_gap: got gnt=%h sel=%0d, want 00/2", gnt, sel);
        end
        step();
        n_tests++;
        if (gnt !== 8'h80 || sel !== 3'd7 || sel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_handoff: got gnt=%h sel=%0d v=%b, want 80/7/1", gnt, sel, sel_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h08;
        step();
        n_tests++;
        if (gnt !== 8'h08) begin
            n_fail++;
            $display("FAIL async_pre_grant: got gnt=%h, want 08", gnt);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 8'h00 || sel_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_drop: got gnt=%h v=%b busy=%b, want 00/0/0", gnt, sel_valid, busy);
        end
        req = 8'h22;
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (gnt !== 8'h02 || sel !== 3'd1) begin
            n_fail++;
            $display("FAIL async_ptr_zero: got gnt=%h sel=%0d, want 02/1", gnt, sel);
        end
    endtask

`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 8'h02;
        step();
        req = 8'h0A;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (gnt !== 8'h02 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_hold[%0d]: got gnt=%h pre=%b, want 02/0", i, gnt, preempt);
            end
        end
        step();
        n_tests++;
        if (gnt !== 8'h00 || preempt !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_revoke: got gnt=%h pre=%b, want 00/1", gnt, preempt);
        end
        step();
        n_tests++;
        if (gnt !== 8'h08 || sel !== 3'd3 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_next: got gnt=%h sel=%0d pre=%b, want 08/3/0", gnt, sel, preempt);
        end
        do_reset();
        req = 8'h02;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (gnt !== 8'h02 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_alone[%0d]: got gnt=%h pre=%b, want 02/0", i, gnt, preempt);
            end
        end
    endtask
`else
    task automatic test_no_preempt();
        do_reset();
        req = 8'h02;
        step();
        req = 8'h0A;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (gnt !== 8'h02 || preempt !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_no_timeout[%0d]: got gnt=%h pre=%b, want 02/0", i, gnt, preempt);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_ptr_advance();
        test_ignore_others();
        test_async_reset();
`ifdef MUX8_ARB_HOLD_TIMEOUT_EN
        test_timeout();
`else
        test_no_preempt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
